// File: rtl/alu_issue_pkg.sv
// alu_issue shared types: ALU ops, opcodes, sequencer states, field positions.
// Ports: none (package). Optional macro ALU_ISSUE_R0_ZERO_EN is used by alu_issue.
package alu_issue_pkg;

  localparam int LUI_SHIFT = 7;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_SLL   = 4'h2,
    ALU_SRL   = 4'h3,
    ALU_SRA   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_SLTU  = 4'h6,
    ALU_XOR   = 4'h7,
    ALU_OR    = 4'h8,
    ALU_AND   = 4'h9,
    ALU_LUI   = 4'hA,
    ALU_AUIPC = 4'hB
  } alu_op_t;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_SLL   = 4'h2,
    OP_SRL   = 4'h3,
    OP_SRA   = 4'h4,
    OP_SLT   = 4'h5,
    OP_SLTU  = 4'h6,
    OP_XOR   = 4'h7,
    OP_OR    = 4'h8,
    OP_AND   = 4'h9,
    OP_ADDI  = 4'hA,
    OP_LUI   = 4'hB,
    OP_AUIPC = 4'hC
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RS1,
    S_RS2,
    S_EXEC,
    S_WB,
    S_ERR
  } issue_state_t;

  function automatic logic [15:0] lui_imm(input logic [8:0] imm9);
    logic [15:0] wide;
    wide = {7'd0, imm9};
    return wide << LUI_SHIFT;
  endfunction

endpackage

// File: rtl/alu_issue_instr_decode.sv
// Combinational decode of a 16-bit instruction into ALU op, fields and flags.
// In: instr. Out: alu_op, rd, rs1, rs2, imm_ext, needs_rs1/rs2, is_pc_rel, is_illegal.
module alu_issue_instr_decode
  import alu_issue_pkg::*;
(
  input  logic [15:0] instr,
  output alu_op_t     alu_op,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [15:0] imm_ext,
  output logic        needs_rs1,
  output logic        needs_rs2,
  output logic        is_pc_rel,
  output logic        is_illegal
);

  logic [3:0]  opc;
  logic        rtype;
  logic [15:0] imm6_sx;

  assign opc = instr[OPC_HI:OPC_LO];
  assign rd  = instr[RD_HI:RD_LO];
  assign rs1 = instr[RS1_HI:RS1_LO];
  assign rs2 = instr[RS2_HI:RS2_LO];
  assign imm6_sx = {{10{instr[IMM6_HI]}}, instr[IMM6_HI:0]};

  always_comb begin
    alu_op     = ALU_ADD;
    imm_ext    = '0;
    needs_rs1  = 1'b0;
    needs_rs2  = 1'b0;
    is_pc_rel  = 1'b0;
    is_illegal = 1'b0;
    rtype      = 1'b0;
    case (opc)
      OP_ADD:  begin rtype = 1'b1; alu_op = ALU_ADD;  end
      OP_SUB:  begin rtype = 1'b1; alu_op = ALU_SUB;  end
      OP_SLL:  begin rtype = 1'b1; alu_op = ALU_SLL;  end
      OP_SRL:  begin rtype = 1'b1; alu_op = ALU_SRL;  end
      OP_SRA:  begin rtype = 1'b1; alu_op = ALU_SRA;  end
      OP_SLT:  begin rtype = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTU: begin rtype = 1'b1; alu_op = ALU_SLTU; end
      OP_XOR:  begin rtype = 1'b1; alu_op = ALU_XOR;  end
      OP_OR:   begin rtype = 1'b1; alu_op = ALU_OR;   end
      OP_AND:  begin rtype = 1'b1; alu_op = ALU_AND;  end
      OP_ADDI: begin
        needs_rs1 = 1'b1;
        alu_op    = ALU_ADD;
        imm_ext   = imm6_sx;
      end
      OP_LUI: begin
        alu_op  = ALU_LUI;
        imm_ext = lui_imm(instr[IMM9_HI:0]);
      end
      OP_AUIPC: begin
        alu_op    = ALU_AUIPC;
        imm_ext   = lui_imm(instr[IMM9_HI:0]);
        is_pc_rel = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
    if (rtype) begin
      needs_rs1 = 1'b1;
      needs_rs2 = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Serial issue stage: accepts one instr, reads rs1/rs2 one per cycle, drives ALU, writes rd.
// Ports: clock/reset, instr_valid/ready/instr/pc, rf_raddr/rdata, alu_*, rf_we/waddr/wdata, done, illegal. Macro: ALU_ISSUE_R0_ZERO_EN.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  output logic [2:0]  rf_raddr,
  input  logic [15:0] rf_rdata,
  output alu_op_t     alu_op,
  output logic [15:0] alu_input1,
  output logic [15:0] alu_input2,
  input  logic [15:0] alu_result,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        done,
  output logic        illegal
);

  issue_state_t state, state_nxt;

  alu_op_t     d_op;
  logic [2:0]  d_rd, d_rs1, d_rs2;
  logic [15:0] d_imm;
  logic        d_rs1_en, d_rs2_en, d_pc_rel, d_illegal;

  alu_op_t     op_q;
  logic [2:0]  rd_q, rs1_q, rs2_q;
  logic [15:0] imm_q, op1_q, op2_q, res_q;
  logic        rs2_en_q;

  logic        accept;
  logic [15:0] rdata;
  logic        wr_ok;

  alu_issue_instr_decode u_dec (
    .instr      (instr),
    .alu_op     (d_op),
    .rd         (d_rd),
    .rs1        (d_rs1),
    .rs2        (d_rs2),
    .imm_ext    (d_imm),
    .needs_rs1  (d_rs1_en),
    .needs_rs2  (d_rs2_en),
    .is_pc_rel  (d_pc_rel),
    .is_illegal (d_illegal)
  );

  assign accept      = instr_valid & (state == S_IDLE) & ~reset;
  assign instr_ready = (state == S_IDLE) & ~reset;
  assign alu_input1  = op1_q;
  assign alu_input2  = op2_q;

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign rdata = (rf_raddr == 3'd0) ? 16'h0000 : rf_rdata;
  assign wr_ok = (rd_q != 3'd0);
`else
  assign rdata = rf_rdata;
  assign wr_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rf_raddr  = 3'd0;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = 16'h0000;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (d_illegal)     state_nxt = S_ERR;
          else if (d_rs1_en) state_nxt = S_RS1;
          else               state_nxt = S_EXEC;
        end
      end
      S_RS1: begin
        rf_raddr  = rs1_q;
        state_nxt = rs2_en_q ? S_RS2 : S_EXEC;
      end
      S_RS2: begin
        rf_raddr  = rs2_q;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_op    = op_q;
        state_nxt = S_WB;
      end
      S_WB: begin
        rf_we     = wr_ok;
        rf_waddr  = rd_q;
        rf_wdata  = res_q;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_q     <= ALU_ADD;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      rs2_en_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_q    <= '0;
    end else begin
      if (accept) begin
        op_q     <= d_op;
        rd_q     <= d_rd;
        rs1_q    <= d_rs1;
        rs2_q    <= d_rs2;
        imm_q    <= d_imm;
        rs2_en_q <= d_rs2_en;
        // LUI/AUIPC need no reads: operands are ready at accept
        if (!d_rs1_en && !d_illegal) begin
          op1_q <= d_pc_rel ? pc : 16'h0000;
          op2_q <= d_imm;
        end
      end
      if (state == S_RS1) begin
        op1_q <= rdata;
        if (!rs2_en_q) op2_q <= imm_q;
      end
      if (state == S_RS2) op2_q <= rdata;
      if (state == S_EXEC) res_q <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with register-file and ALU models.
// Scoreboard of expected writebacks checked by a monitor; per-scenario inline checks.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] pc = '0;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  alu_op_t     alu_op;
  logic [15:0] alu_input1, alu_input2;
  logic [15:0] alu_result;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        done, illegal;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    int          wb;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  logic        poke_en = 1'b0;
  logic [2:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  logic [15:0] regs [8];

  alu_issue dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .alu_op      (alu_op),
    .alu_input1  (alu_input1),
    .alu_input2  (alu_input2),
    .alu_result  (alu_result),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (poke_en)    regs[poke_addr] <= poke_data;
    else if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  assign rf_rdata = regs[rf_raddr];

  always_comb begin
    case (alu_op)
      ALU_ADD:   alu_result = alu_input1 + alu_input2;
      ALU_SUB:   alu_result = alu_input1 - alu_input2;
      ALU_SLL:   alu_result = alu_input1 << alu_input2[3:0];
      ALU_SRL:   alu_result = alu_input1 >> alu_input2[3:0];
      ALU_SRA:   alu_result = 16'($signed(alu_input1) >>> alu_input2[3:0]);
      ALU_SLT:   alu_result = {15'd0, $signed(alu_input1) < $signed(alu_input2)};
      ALU_SLTU:  alu_result = {15'd0, alu_input1 < alu_input2};
      ALU_XOR:   alu_result = alu_input1 ^ alu_input2;
      ALU_OR:    alu_result = alu_input1 | alu_input2;
      ALU_AND:   alu_result = alu_input1 & alu_input2;
      ALU_LUI:   alu_result = alu_input2;
      ALU_AUIPC: alu_result = alu_input1 + alu_input2;
      default:   alu_result = 16'h0000;
    endcase
  end

  // writeback monitor: every done/rf_we must match the scoreboard head
  always @(negedge clock) begin
    if (rf_we || done) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: we=%0b done=%0b waddr=%0d wdata=%h cyc=%0d, required no writeback",
                 rf_we, done, rf_waddr, rf_wdata, cyc);
      end else begin
        me = sb.pop_front();
        if (rf_we !== me.we || done !== 1'b1 || cyc != me.wb ||
            (me.we && (rf_waddr !== me.waddr || rf_wdata !== me.wdata))) begin
          fails++;
          $display("FAIL wb: we=%0b done=%0b waddr=%0d wdata=%h cyc=%0d, required we=%0b done=1 waddr=%0d wdata=%h cyc=%0d",
                   rf_we, done, rf_waddr, rf_wdata, cyc, me.we, me.waddr, me.wdata, me.wb);
        end
      end
    end
  end

  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    @(negedge clock);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // offers an instruction until accepted; returns at negedge T0+1
  task automatic send(input logic [15:0] i, input logic [15:0] p, input int lat,
                      input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      output int t0);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    t0 = -1;
    instr = i; pc = p; instr_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (instr_ready === 1'b1) begin
        ok = 1'b1;
        t0 = cyc;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL accept_timeout: instr=%h not accepted, required accept within 30 cycles", i);
    end else if (lat > 0) begin
      e.we = we; e.waddr = wa; e.wdata = wd; e.wb = t0 + lat;
      sb.push_back(e);
    end
    @(negedge clock);
    instr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 12 && sb.size() != 0; k++) begin
      @(negedge clock);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d writebacks pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (instr_ready !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl: ready=%b we=%b done=%b ill=%b, required all 0",
               instr_ready, rf_we, done, illegal);
    end
    checks++;
    if (alu_op !== ALU_ADD || alu_input1 !== 16'h0 || alu_input2 !== 16'h0 ||
        rf_raddr !== 3'd0 || rf_waddr !== 3'd0 || rf_wdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_data: op=%0d in1=%h in2=%h ra=%0d wa=%0d wd=%h, required 0/0/0/0/0/0",
               alu_op, alu_input1, alu_input2, rf_raddr, rf_waddr, rf_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: ready=%b, required 1", instr_ready);
    end
  endtask

  task automatic test_add();
    int t0;
    poke(3'd1, 16'h0005);
    poke(3'd2, 16'h0003);
    send(16'h0650, 16'h0000, 4, 1'b1, 3'd3, 16'h0008, t0);
    checks++;
    if (rf_raddr !== 3'd1 || instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL add_rs1: raddr=%0d ready=%b, required 1/0", rf_raddr, instr_ready);
    end
    @(negedge clock);
    checks++;
    if (rf_raddr !== 3'd2) begin
      fails++;
      $display("FAIL add_rs2: raddr=%0d, required 2", rf_raddr);
    end
    @(negedge clock);
    checks++;
    if (alu_op !== ALU_ADD || alu_input1 !== 16'h0005 || alu_input2 !== 16'h0003 || rf_raddr !== 3'd0) begin
      fails++;
      $display("FAIL add_exec: op=%0d in1=%h in2=%h ra=%0d, required 0/0005/0003/0",
               alu_op, alu_input1, alu_input2, rf_raddr);
    end
    wait_drain();
  endtask

  task automatic test_addi();
    int t0;
    poke(3'd1, 16'h0010);
    send(16'hA47F, 16'h0000, 3, 1'b1, 3'd2, 16'h000F, t0);
    checks++;
    if (rf_raddr !== 3'd1) begin
      fails++;
      $display("FAIL addi_rs1: raddr=%0d, required 1", rf_raddr);
    end
    @(negedge clock);
    checks++;
    if (alu_op !== ALU_ADD || alu_input1 !== 16'h0010 || alu_input2 !== 16'hFFFF || rf_raddr !== 3'd0) begin
      fails++;
      $display("FAIL addi_exec: op=%0d in1=%h in2=%h ra=%0d, required 0/0010/ffff/0",
               alu_op, alu_input1, alu_input2, rf_raddr);
    end
    wait_drain();
  endtask

  task automatic test_lui();
    int t0;
    send(16'hB3FF, 16'h0000, 2, 1'b1, 3'd1, 16'hFF80, t0);
    checks++;
    if (alu_op !== ALU_LUI || alu_input2 !== 16'hFF80 || rf_raddr !== 3'd0) begin
      fails++;
      $display("FAIL lui_exec: op=%0d in2=%h ra=%0d, required %0d/ff80/0",
               alu_op, alu_input2, rf_raddr, ALU_LUI);
    end
    @(negedge clock);
    checks++;
    if (alu_op !== ALU_ADD) begin
      fails++;
      $display("FAIL lui_wb_op: op=%0d, required 0", alu_op);
    end
    wait_drain();
  endtask

  task automatic test_auipc();
    int t0;
    send(16'hC401, 16'h0100, 2, 1'b1, 3'd2, 16'h0180, t0);
    checks++;
    if (alu_op !== ALU_AUIPC || alu_input1 !== 16'h0100 || alu_input2 !== 16'h0080) begin
      fails++;
      $display("FAIL auipc_exec: op=%0d in1=%h in2=%h, required %0d/0100/0080",
               alu_op, alu_input1, alu_input2, ALU_AUIPC);
    end
    wait_drain();
  endtask

  // r1=ff80 (LUI), r2=0180 (AUIPC) -> held ADD writes r3=0100
  task automatic test_illegal();
    int t0, t1;
    send(16'hF000, 16'h0000, 0, 1'b0, 3'd0, 16'h0, t0);
    checks++;
    if (illegal !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b0) begin
      fails++;
      $display("FAIL ill_pulse: ill=%b we=%b done=%b ready=%b, required 1/0/0/0",
               illegal, rf_we, done, instr_ready);
    end
    send(16'h0650, 16'h0000, 4, 1'b1, 3'd3, 16'h0100, t1);
    checks++;
    if (t1 != t0 + 2) begin
      fails++;
      $display("FAIL ill_reaccept: accept cyc=%0d, required %0d", t1, t0 + 2);
    end
    checks++;
    if (illegal !== 1'b0 || rf_raddr !== 3'd1) begin
      fails++;
      $display("FAIL ill_after: ill=%b ra=%0d, required 0/1", illegal, rf_raddr);
    end
    wait_drain();
  endtask

  task automatic test_rtype();
    alu_op_t     ops [9] = '{ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT,
                             ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND};
    logic [15:0] res [9] = '{16'h7FFE, 16'h0008, 16'h1000, 16'hF000, 16'h0001,
                             16'h0000, 16'h8002, 16'h8003, 16'h0001};
    int t0;
    logic [3:0] opc;
    poke(3'd4, 16'h8001);
    poke(3'd5, 16'h0003);
    for (int i = 0; i < 9; i++) begin
      opc = 4'(i + 1);
      send({opc, 12'hD28}, 16'h0000, 4, 1'b1, 3'd6, res[i], t0);
      repeat (2) @(negedge clock);
      checks++;
      if (alu_op !== ops[i] || alu_input1 !== 16'h8001 || alu_input2 !== 16'h0003) begin
        fails++;
        $display("FAIL rtype_exec[%0d]: op=%0d in1=%h in2=%h, required %0d/8001/0003",
                 i, alu_op, alu_input1, alu_input2, ops[i]);
      end
      wait_drain();
    end
  endtask

  task automatic test_rd_src();
    int t0;
    poke(3'd1, 16'h1234);
    send(16'h0248, 16'h0000, 4, 1'b1, 3'd1, 16'h2468, t0);
    checks++;
    if (rf_raddr !== 3'd1) begin
      fails++;
      $display("FAIL same_rs1: raddr=%0d, required 1", rf_raddr);
    end
    @(negedge clock);
    checks++;
    if (rf_raddr !== 3'd1) begin
      fails++;
      $display("FAIL same_rs2: raddr=%0d, required 1", rf_raddr);
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    int t0;
    bit seen;
    seen = 1'b0;
    send(16'h0650, 16'h0000, 0, 1'b0, 3'd0, 16'h0, t0);
    @(negedge clock);
    checks++;
    if (rf_raddr !== 3'd2) begin
      fails++;
      $display("FAIL mrst_rs2: raddr=%0d, required 2", rf_raddr);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b0 || rf_we !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mrst_hold: ready=%b we=%b done=%b, required 0/0/0", instr_ready, rf_we, done);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL mrst_ready: ready=%b, required 1", instr_ready);
    end
    for (int k = 0; k < 8; k++) begin
      if (rf_we !== 1'b0 || done !== 1'b0) seen = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL mrst_quiet: writeback seen after reset, required none");
    end
  endtask

`ifdef ALU_ISSUE_R0_ZERO_EN
  task automatic test_r0();
    int t0;
    poke(3'd1, 16'h0011);
    poke(3'd2, 16'h0022);
    send(16'h0050, 16'h0000, 4, 1'b0, 3'd0, 16'h0033, t0);
    wait_drain();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_lui();
    test_auipc();
    test_illegal();
    test_rtype();
    test_rd_src();
    test_mid_reset();
`ifdef ALU_ISSUE_R0_ZERO_EN
    test_r0();
`endif
    repeat (2) @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_empty: %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
